// File: rtl/umni_pkg.sv
// rtl/umni_pkg.sv - shared constants for serializador_7bits; frame length follows SERIALIZADOR_PARIDADE_EN
package umni_pkg;

    localparam int LARGURA_DADO     = 7;
    localparam int LARGURA_CONTADOR = 8;
    localparam int LARGURA_INDICE   = 3;

    // FSM encoding kept as plain constants so older blocks can share it
    localparam logic [2:0] OCIOSO   = 3'd0;
    localparam logic [2:0] INICIO   = 3'd1;
    localparam logic [2:0] DADOS    = 3'd2;
    localparam logic [2:0] PARIDADE = 3'd3;
    localparam logic [2:0] PARADA   = 3'd4;

`ifdef SERIALIZADOR_PARIDADE_EN
    localparam int BITS_QUADRO = 10;
`else
    localparam int BITS_QUADRO = 9;
`endif

    // Even parity bit: XOR of all data bits
    function automatic logic paridade_par(input logic [LARGURA_DADO-1:0] dado);
        return ^dado;
    endfunction

endpackage

// File: rtl/serializador_7bits_if.sv
// rtl/serializador_7bits_if.sv - parallel load handshake and serial line bundle
interface serializador_7bits_if;
    import umni_pkg::*;

    logic [LARGURA_DADO-1:0] entrada;
    logic                    carrega;
    logic                    pronto;
    logic                    saida_serial;
    logic                    ocupado;
    logic                    fim;

    modport master (
        output entrada, carrega,
        input  pronto, saida_serial, ocupado, fim
    );

    modport slave (
        input  entrada, carrega,
        output pronto, saida_serial, ocupado, fim
    );

endinterface

// File: rtl/serializador_7bits_gerador_tick_bit.sv
// rtl/serializador_7bits_gerador_tick_bit.sv - bit-period counter, tick on the last cycle of each bit
module gerador_tick_bit
    import umni_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic limpa,
    output logic tick
);

    logic [LARGURA_CONTADOR-1:0] contador;

    assign tick = (contador == LARGURA_CONTADOR'(CICLOS_POR_BIT - 1));

    // Count cycles within a bit; wrap on tick, hold at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contador <= '0;
        end else if (limpa || tick) begin
            contador <= '0;
        end else begin
            contador <= contador + 1'b1;
        end
    end

endmodule

// File: rtl/serializador_7bits.sv
// rtl/serializador_7bits.sv - 7-bit LSB-first serializer, optional parity bit via SERIALIZADOR_PARIDADE_EN
module serializador_7bits
    import umni_pkg::*;
#(
    parameter int CICLOS_POR_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serializador_7bits_if.slave  bus
);

    logic [2:0]                estado;
    logic [LARGURA_DADO-1:0]   palavra;
    logic [LARGURA_INDICE-1:0] indice;
    logic [LARGURA_INDICE-1:0] prox_indice;
    logic                      armado;
    logic                      tick;
    logic                      aceita;
    logic                      saida_q;
    logic                      pronto_q;
    logic                      ocupado_q;
    logic                      fim_q;

    // The counter idles at zero in OCIOSO so every frame state starts a full bit period
    gerador_tick_bit #(
        .CICLOS_POR_BIT(CICLOS_POR_BIT)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .limpa (estado == OCIOSO),
        .tick  (tick)
    );

    assign prox_indice = indice + 1'b1;
    // armado blocks acceptance on the first edge after reset release
    assign aceita      = bus.carrega && (estado == OCIOSO) && armado;

    assign bus.saida_serial = saida_q;
    assign bus.pronto       = pronto_q;
    assign bus.ocupado      = ocupado_q;
    assign bus.fim          = fim_q;

    // Frame FSM; outputs are registered with the value of the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado    <= OCIOSO;
            palavra   <= '0;
            indice    <= '0;
            armado    <= 1'b0;
            saida_q   <= 1'b1;
            pronto_q  <= 1'b1;
            ocupado_q <= 1'b0;
            fim_q     <= 1'b0;
        end else begin
            armado <= 1'b1;
            fim_q  <= 1'b0;
            case (estado)
                OCIOSO: begin
                    if (aceita) begin
                        estado    <= INICIO;
                        palavra   <= bus.entrada;
                        indice    <= '0;
                        saida_q   <= 1'b0;
                        pronto_q  <= 1'b0;
                        ocupado_q <= 1'b1;
                    end
                end
                INICIO: begin
                    if (tick) begin
                        estado  <= DADOS;
                        indice  <= '0;
                        saida_q <= palavra[0];
                    end
                end
                DADOS: begin
                    if (tick) begin
                        if (indice == LARGURA_INDICE'(LARGURA_DADO - 1)) begin
                            indice  <= '0;
`ifdef SERIALIZADOR_PARIDADE_EN
                            estado  <= PARIDADE;
                            saida_q <= paridade_par(palavra);
`else
                            estado  <= PARADA;
                            saida_q <= 1'b1;
`endif
                        end else begin
                            indice  <= prox_indice;
                            saida_q <= palavra[prox_indice];
                        end
                    end
                end
`ifdef SERIALIZADOR_PARIDADE_EN
                PARIDADE: begin
                    if (tick) begin
                        estado  <= PARADA;
                        indice  <= '0;
                        saida_q <= 1'b1;
                    end
                end
`endif
                PARADA: begin
                    if (tick) begin
                        estado    <= OCIOSO;
                        indice    <= '0;
                        saida_q   <= 1'b1;
                        pronto_q  <= 1'b1;
                        ocupado_q <= 1'b0;
                        fim_q     <= 1'b1;
                    end
                end
                default: begin
                    estado    <= OCIOSO;
                    indice    <= '0;
                    saida_q   <= 1'b1;
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializador_7bits.sv
// tb/tb_serializador_7bits.sv - scoreboard bench for serializador_7bits (C=4 and C=1 instances)
module tb_serializador_7bits;

    typedef struct packed {
        logic saida;
        logic pronto;
        logic fim;
    } esperado_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    serializador_7bits_if if4 ();
    serializador_7bits_if if1 ();

    serializador_7bits #(.CICLOS_POR_BIT(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
    serializador_7bits #(.CICLOS_POR_BIT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

    always #5 clk = ~clk;

    esperado_t fila[2][$];
    bit [1:0]  armado_m = 2'b00;
    int        aceitos[2];
    int        fims[2];
    int        ciclo = 0;
    int        n_aval = 0;
    int        n_falhas = 0;
    int        bits_q;

    function automatic int ciclos_bit(input int k);
        return (k == 0) ? 4 : 1;
    endfunction

    function automatic logic [3:0] saidas(input int k);
        if (k == 0) return {if4.saida_serial, if4.pronto, if4.ocupado, if4.fim};
        return {if1.saida_serial, if1.pronto, if1.ocupado, if1.fim};
    endfunction

    task automatic verifica(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
        n_aval++;
        if (atual !== esperado) begin
            n_falhas++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, atual, esperado, $time);
        end
    endtask

    // Reference frame: start 0, data LSB first, optional even parity, stop 1, each held C cycles, then one fim cycle
    task automatic empilha(input int k, input logic [6:0] w);
        logic b[$];
        b.push_back(1'b0);
        for (int i = 0; i < 7; i++) b.push_back(w[i]);
`ifdef SERIALIZADOR_PARIDADE_EN
        b.push_back(($countones(w) % 2) == 1);
`endif
        b.push_back(1'b1);
        foreach (b[j]) repeat (ciclos_bit(k)) fila[k].push_back('{saida: b[j], pronto: 1'b0, fim: 1'b0});
        fila[k].push_back('{saida: 1'b1, pronto: 1'b1, fim: 1'b1});
    endtask

    task automatic poe(input int k, input logic c, input logic [6:0] w);
        if (k == 0) begin
            if4.carrega = c;
            if4.entrada = w;
        end else begin
            if1.carrega = c;
            if1.entrada = w;
        end
    endtask

    function automatic logic car(input int k);
        return (k == 0) ? if4.carrega : if1.carrega;
    endfunction

    function automatic logic [6:0] ent(input int k);
        return (k == 0) ? if4.entrada : if1.entrada;
    endfunction

    // Model: a word is taken when the line is free (nothing pending) and reset has been released for one edge
    initial forever begin
        @(posedge clk);
        ciclo++;
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (armado_m[k] && fila[k].size() == 0 && car(k)) begin
                    empilha(k, ent(k));
                    aceitos[k]++;
                end
                armado_m[k] = 1'b1;
            end
        end
    end

    // Monitor: every cycle compare the line and flags against the next expected record (idle when none)
    initial forever begin
        esperado_t  e;
        logic [3:0] a;
        @(negedge clk);
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (fila[k].size() > 0) e = fila[k].pop_front();
                else e = '{saida: 1'b1, pronto: 1'b1, fim: 1'b0};
                a = saidas(k);
                verifica($sformatf("linha_dut%0d", k), 32'(a), 32'({e.saida, e.pronto, ~e.pronto, e.fim}));
                if (a[0]) fims[k]++;
            end
        end
    end

    task automatic envia(input int k, input logic [6:0] w);
        int base;
        bit ok;
        base = aceitos[k];
        ok = 1'b0;
        poe(k, 1'b1, w);
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            if (aceitos[k] != base) begin
                ok = 1'b1;
                break;
            end
        end
        poe(k, 1'b0, w);
        verifica($sformatf("aceite_dut%0d", k), 32'(ok), 32'd1);
    endtask

    task automatic aplica_reset();
        rst_n = 1'b0;
        fila[0].delete();
        fila[1].delete();
        armado_m = 2'b00;
    endtask

    initial begin
        int n, t1, t2, base_fim, base_ac;
        logic [6:0] w;
        bits_q = 9;
`ifdef SERIALIZADOR_PARIDADE_EN
        bits_q = 10;
`endif
        poe(0, 1'b0, 7'h00);
        poe(1, 1'b0, 7'h00);

        #2;
        aplica_reset();
        #1;
        verifica("reset_dut0", 32'(saidas(0)), 32'h0C);
        verifica("reset_dut1", 32'(saidas(1)), 32'h0C);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 0x55 at 4 cycles per bit: fim must arrive bits*4+1 cycles after the accept edge
        envia(0, 7'h55);
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            n++;
            if (if4.fim) break;
        end
        verifica("fim_ciclo_55", 32'(n), 32'(bits_q * 4 + 1));

        // Parity words; the scoreboard carries the parity expectation when enabled
        envia(0, 7'h07);
        envia(0, 7'h03);

        // Back-to-back 0x7F at one cycle per bit: second accept on the fim cycle
        base_fim = fims[1];
        envia(1, 7'h7F);
        t1 = ciclo;
        envia(1, 7'h7F);
        t2 = ciclo;
        verifica("intervalo_b2b", 32'(t2 - t1), 32'(bits_q + 1));
        repeat (bits_q + 4) @(posedge clk);
        #1;
        verifica("fims_b2b", 32'(fims[1] - base_fim), 32'd2);

        // Random words, random target, random gaps
        for (int i = 0; i < 20; i++) begin
            int k;
            k = int'($urandom_range(0, 1));
            envia(k, 7'($urandom));
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        // carrega held high while entrada changes every cycle
        base_ac = aceitos[0];
        for (int i = 0; i < 90; i++) begin
            poe(0, 1'b1, 7'($urandom));
            @(posedge clk);
            #1;
        end
        poe(0, 1'b0, 7'h00);
        verifica("aceites_continuo", 32'(aceitos[0] - base_ac >= 2), 32'd1);

        // Reset in the middle of data bit 3
        w = 7'($urandom);
        envia(0, w);
        repeat (17) @(posedge clk);
        #3;
        verifica("bit3_antes_reset", 32'(if4.saida_serial), 32'(w[3]));
        base_fim = fims[0];
        aplica_reset();
        #1;
        verifica("reset_meio_dut0", 32'(saidas(0)), 32'h0C);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        verifica("sem_fim_abortado", 32'(fims[0]), 32'(base_fim));

        // carrega already high on release: first edge ignored, second accepts
        aplica_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        base_ac = aceitos[1];
        t1 = ciclo;
        envia(1, 7'h2A);
        verifica("aceite_pos_reset", 32'(ciclo - t1), 32'd2);

        n = 0;
        while ((fila[0].size() != 0 || fila[1].size() != 0) && n < 300) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        verifica("drenagem", 32'(fila[0].size() + fila[1].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
        $finish;
    end

endmodule

// File: doc/serializador_7bits.md
SERIALIZADOR_7BITS -- requirements
Module: serializador_7bits

Interface
REQ-001 SHALL have parameter CICLOS_POR_BIT, default 4, clock cycles each serial bit is held (legal 1..255).
REQ-002 SHALL have port clk  input  1  system clock, all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port entrada  input  7  parallel word to transmit.
REQ-005 SHALL have port carrega  input  1  request: entrada valid this cycle.
REQ-006 SHALL have port pronto  output  1  block can accept a word this cycle.
REQ-007 SHALL have port saida_serial  output  1  serial line, idle high.
REQ-008 SHALL have port ocupado  output  1  frame in progress.
REQ-009 SHALL have port fim  output  1  one-cycle pulse after stop bit completes.

Function
REQ-010 SHALL accept a word only on a rising edge where carrega=1 and pronto=1; entrada captured into an internal 7-bit register that cycle.
REQ-011 SHALL ignore carrega while pronto=0; no queuing, no corruption of frame in flight.
REQ-012 SHALL implement FSM OCIOSO -> INICIO -> DADOS -> [PARIDADE] -> PARADA -> OCIOSO.
REQ-013 SHALL drive saida_serial=1 in OCIOSO, 0 in INICIO, captured bit in DADOS (LSB first, bit 0..6), 1 in PARADA.
REQ-014 SHALL hold each FSM state except OCIOSO for exactly CICLOS_POR_BIT cycles (DADOS: 7 x CICLOS_POR_BIT).
REQ-015 SHALL enter INICIO on the edge that accepts the word; saida_serial falls in the first cycle after acceptance (latency 1 cycle).
REQ-016 SHALL assert pronto=1 only in OCIOSO; ocupado = not pronto.
REQ-017 SHALL pulse fim=1 for exactly one cycle, the first cycle back in OCIOSO after PARADA.
REQ-018 SHALL accept a new word in the same cycle fim=1 (back-to-back frames, no idle gap beyond that cycle).
REQ-019 SHALL use a bit-cycle counter of 8 bits and a bit index of 3 bits, both cleared on every state transition; counter terminal value CICLOS_POR_BIT-1.
REQ-020 SHALL treat CICLOS_POR_BIT=1 as one cycle per bit with no special case.
REQ-021 SHALL be registered-output: saida_serial, pronto, ocupado, fim driven from flops, no combinational path from carrega or entrada.

Reset
REQ-022 SHALL on rst_n=0, immediately and regardless of clk: FSM=OCIOSO, saida_serial=1, pronto=1, ocupado=0, fim=0, counters and captured word=0.
REQ-023 SHALL abort any frame in flight on reset mid-operation; no fim pulse for the aborted frame.
REQ-024 SHALL ignore carrega in the first cycle after rst_n deasserts; accept from the second cycle.

Configuration
REQ-025 SHALL, with macro SERIALIZADOR_PARIDADE_EN defined, insert PARIDADE state after DADOS driving even parity (XOR of the 7 data bits) for CICLOS_POR_BIT cycles; frame = 10 bits.
REQ-026 SHALL, without SERIALIZADOR_PARIDADE_EN, go DADOS -> PARADA directly; frame = 9 bits; no parity logic synthesized.

Structure
REQ-027 SHALL place FSM state encoding, LARGURA_DADO=7 and frame-length constants in shared package umni_pkg.
REQ-028 SHALL use one sub-module gerador_tick_bit (bit-period counter, emits tick at CICLOS_POR_BIT-1, synchronous clear).

Verification
REQ-029 SHALL check: reset then entrada=7'h55, carrega=1 one cycle, CICLOS_POR_BIT=4 -> line 0,1,0,1,0,1,0,1,1 each 4 cycles (start, LSB-first data, stop), fim pulse at cycle 37 after accept.
REQ-030 SHALL check: carrega held high with entrada changing mid-frame -> frame carries only the word captured at accept; next word accepted on fim cycle.
REQ-031 SHALL check: rst_n low during DADOS bit 3 -> saida_serial=1, pronto=1 same cycle, no fim.
REQ-032 SHALL check: SERIALIZADOR_PARIDADE_EN, entrada=7'h07 -> parity bit 1; entrada=7'h03 -> parity bit 0; frame 10 bits.
REQ-033 SHALL check: CICLOS_POR_BIT=1, entrada=7'h7F back-to-back twice -> 18 consecutive bit cycles plus one OCIOSO cycle between frames, two fim pulses.
